// File: rtl/tdc_readout_sequencer.sv
// tdc_readout_sequencer: per-event TDC controller. A trigger fires one START
// pulse, an acceptance window captures one hit per channel into a pending
// slot, a round-robin arbiter drains hits into a single output register, and
// every event closes with a trailer word carrying hit count and event number.
module tdc_readout_sequencer #(
  parameter int N_CH    = 4,
  parameter int TIME_W  = 8,
  parameter int WIN_LEN = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   TRIG,
  output logic                   BUSY,
  output logic                   TDC_START,
  input  logic [N_CH*TIME_W-1:0] TDC_TIME,
  input  logic [N_CH-1:0]        TDC_VALID,
  output logic [TIME_W+7:0]      OUT_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   OUT_LAST,
  output logic [TIME_W-1:0]      EVT_CNT
);

  localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CAND_W = PTR_W + 1;
  localparam int WIN_W  = 16;
  localparam int WORD_W = TIME_W + 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WINDOW  = 2'd1,
    S_DRAIN   = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [3:0]          hit_cnt_q, hit_cnt_d;
  logic [TIME_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [N_CH-1:0]     pend_q, pend_d;
  logic [N_CH-1:0]     ovf_q, ovf_d;
  logic [TIME_W-1:0]   time_q [N_CH];
  logic [TIME_W-1:0]   time_d [N_CH];
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic                in_window;
  logic                out_xfer;
  logic                out_free;
  logic [N_CH-1:0]     req;
  logic [CAND_W-1:0]   cand;
  logic [PTR_W-1:0]    cand_idx;
  logic                gnt_found;
  logic [PTR_W-1:0]    gnt_idx;
  logic [TIME_W-1:0]   gnt_time;
  logic                gnt_ovf;
  logic                hit_load;

  assign in_window = (state_q == S_WINDOW);
  assign out_xfer  = out_valid_q && OUT_READY;
  assign out_free  = !out_valid_q || OUT_READY;
  // A hit arriving this cycle competes directly, so an idle output register
  // can take it on the capture edge without a pending-slot detour.
  assign req       = pend_q | (TDC_VALID & {N_CH{in_window}});

  // Round-robin arbiter: lowest requesting index at or after the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_time  = '0;
    gnt_ovf   = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, ptr_q} + CAND_W'(k);
      if (cand >= CAND_W'(N_CH)) cand = cand - CAND_W'(N_CH);
      cand_idx = cand[PTR_W-1:0];
      if (!gnt_found && req[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
        if (pend_q[cand_idx]) begin
          gnt_time = time_q[cand_idx];
          gnt_ovf  = ovf_q[cand_idx];
        end else begin
          gnt_time = TDC_TIME[cand_idx*TIME_W +: TIME_W];
          gnt_ovf  = 1'b0;
        end
      end
    end
  end

  assign hit_load = gnt_found && out_free &&
                    ((state_q == S_WINDOW) || (state_q == S_DRAIN));

  // Next-state, capture, output-register and counter logic.
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    evt_cnt_d   = evt_cnt_q;
    ptr_d       = ptr_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    time_d      = time_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (hit_load) begin
      out_data_d  = {1'b0, gnt_ovf, 3'b000, 3'(gnt_idx), gnt_time};
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      ptr_d       = (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      if (hit_cnt_q != 4'd15) hit_cnt_d = hit_cnt_q + 4'd1;
      pend_d[gnt_idx] = 1'b0;
      ovf_d[gnt_idx]  = 1'b0;
    end

    // Per-channel capture; a granted slot frees up in time for a new hit.
    for (int i = 0; i < N_CH; i++) begin
      if (in_window && TDC_VALID[i]) begin
        if (hit_load && (gnt_idx == PTR_W'(i)) && !pend_q[i]) begin
          // Hit went straight to the output register.
        end else if (!pend_q[i] || (hit_load && (gnt_idx == PTR_W'(i)))) begin
          pend_d[i] = 1'b1;
          ovf_d[i]  = 1'b0;
          time_d[i] = TDC_TIME[i*TIME_W +: TIME_W];
        end else begin
          ovf_d[i]  = 1'b1;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (TRIG) begin
          state_d   = S_WINDOW;
          win_cnt_d = '0;
          hit_cnt_d = '0;
        end
      end
      S_WINDOW: begin
        if (win_cnt_q == WIN_W'(WIN_LEN - 1)) state_d = S_DRAIN;
        else                                  win_cnt_d = win_cnt_q + 1'b1;
      end
      S_DRAIN: begin
        if ((pend_q == '0) && out_free) begin
          out_data_d  = {1'b1, 3'b000, hit_cnt_q, evt_cnt_q};
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (out_xfer) begin
          evt_cnt_d = evt_cnt_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset discards the event in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      win_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      evt_cnt_q   <= '0;
      ptr_q       <= '0;
      pend_q      <= '0;
      ovf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      evt_cnt_q   <= evt_cnt_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Per-channel time holders.
  // NOTE: time_q is only read when its pend_q bit is set, so it needs no reset.
  always_ff @(posedge CLK) begin
    time_q <= time_d;
  end

  assign BUSY      = (state_q != S_IDLE);
  assign TDC_START = (state_q == S_WINDOW) && (win_cnt_q == '0);
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign EVT_CNT   = evt_cnt_q;

endmodule
